// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: access width encoding, FSM state codes
// and byte-lane helpers used by the arbiter and the lane aligner.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } memory_mask_t;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_IF_WAIT = 2'd1;
  localparam arb_state_t ST_D_WAIT  = 2'd2;
  localparam arb_state_t ST_RESP    = 2'd3;

  function automatic logic [3:0] lane_be(input memory_mask_t mask, input logic [1:0] off);
    case (mask)
      MEM_BYTE: return 4'b0001 << off;
      MEM_HALF: return 4'b0011 << off;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic lane_misaligned(input memory_mask_t mask, input logic [1:0] off);
    case (mask)
      MEM_HALF: return off[0];
      MEM_WORD: return off != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Combinational byte-lane aligner: store byte enables and lane replication,
// load lane extraction with optional sign extension, and alignment check.
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  memory_mask_t mask,
  input  logic [1:0]   addr_lo,
  input  logic [31:0]  wdata,
  input  logic [31:0]  rdata,
  input  logic         sign_ext,
  output logic [3:0]   be,
  output logic [31:0]  wdata_lanes,
  output logic [31:0]  rdata_ext,
  output logic         misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be          = lane_be(mask, addr_lo);
    misaligned  = lane_misaligned(mask, addr_lo);
    wdata_lanes = wdata;
    rdata_ext   = rdata;
    case (mask)
      MEM_BYTE: begin
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      end
      MEM_HALF: begin
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{sign_ext & half_lane[15]}}, half_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory between fetch and load/store; data wins
// except when fetch has waited out MAX_DATA_STREAK data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         halt,
  input  logic         if_req,
  input  logic [31:0]  if_addr,
  output logic [31:0]  if_rdata,
  output logic         if_ack,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [31:0]  d_addr,
  input  logic [31:0]  d_wdata,
  input  memory_mask_t d_mask,
  input  logic         d_sign_ext,
  output logic [31:0]  d_rdata,
  output logic         d_ack,
  output logic         d_err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_be,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ack,
  output logic         idle
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  arb_state_t    state;
  logic [SW-1:0] streak;
  logic          grant_d;
  logic          grant_f;
  logic [3:0]    be;
  logic [31:0]   wdata_lanes;
  logic [31:0]   rdata_ext;
  logic          misaligned;

  // The requester holds mask/addr until its ack, so the live fields are valid
  // both at grant time and when the read word comes back.
  mem_lane_align u_align (
    .mask        (d_mask),
    .addr_lo     (d_addr[1:0]),
    .wdata       (d_wdata),
    .rdata       (mem_rdata),
    .sign_ext    (d_sign_ext),
    .be          (be),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext),
    .misaligned  (misaligned)
  );

  always_comb begin
    grant_d = 1'b0;
    grant_f = 1'b0;
    if (state == ST_IDLE && !halt) begin
      if (d_req && !(if_req && streak == STREAK_MAX)) grant_d = 1'b1;
      else if (if_req)                                grant_f = 1'b1;
    end
  end

  assign idle = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      streak    <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      if (!if_req) streak <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            if (if_req && streak != STREAK_MAX) streak <= streak + SW'(1);
            if (misaligned) begin
              d_ack <= 1'b1;
              d_err <= 1'b1;
              state <= ST_RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= word_addr(d_addr);
              mem_wdata <= wdata_lanes;
              mem_be    <= be;
              state     <= ST_D_WAIT;
            end
          end else if (grant_f) begin
            streak    <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= word_addr(if_addr);
            mem_wdata <= '0;
            mem_be    <= 4'b1111;
            state     <= ST_IF_WAIT;
          end
        end
        ST_IF_WAIT: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
            state    <= ST_RESP;
          end
        end
        ST_D_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            d_rdata <= rdata_ext;
            d_ack   <= 1'b1;
            state   <= ST_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing one single-port, variable-latency memory between the instruction-fetch path and the load/store path of the core. Data accesses normally win; a streak counter guarantees fetch progress. Byte enables, write lane replication, read lane extraction and sign extension follow the memory mask and sign-extension controls the decoder already produces. Accesses are checked for alignment, and new grants are frozen while the core is halted on ebreak.

## Interface
- MAX_DATA_STREAK, 4: max consecutive data grants while fetch is pending (≥1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- halt  in  1  no new grants while high (driven from ebreak latch)
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch address (word-aligned by contract)
- if_rdata  out  32  fetched word, valid with if_ack
- if_ack  out  1  one-cycle completion pulse
- d_req  in  1  load/store request, held until d_ack
- d_we  in  1  1 = store
- d_addr  in  32  byte address
- d_wdata  in  32  store data, right-aligned
- d_mask  in  memory_mask_t  MEM_BYTE / MEM_HALF / MEM_WORD
- d_sign_ext  in  1  sign-extend byte/half loads
- d_rdata  out  32  aligned, extended load data, valid with d_ack
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  misaligned access; valid with d_ack
- mem_req  out  1  memory request, held until mem_ack
- mem_we, mem_addr[31:0], mem_wdata[31:0], mem_be[3:0]  out  request fields, stable while mem_req
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  completion, ≥1 cycle after mem_req rises
- idle  out  1  FSM in IDLE

## Operation
- FSM states: IDLE, IF_WAIT, D_WAIT, RESP.
- IDLE, halt=0: pick winner among requests not being acked this cycle. Data wins unless if_req=1 and streak==MAX_DATA_STREAK.
- On grant, register mem_* fields and go to IF_WAIT/D_WAIT. Misaligned data instead skips memory and goes to RESP with err.
- Misaligned: MEM_HALF with addr[0]=1, MEM_WORD with addr[1:0]≠0. MEM_BYTE is never misaligned.
- mem_addr = {addr[31:2],2'b00}.
- mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- *_WAIT: on mem_ack, capture result and go to RESP; drop mem_req the same edge.
- Load result: byte mem_rdata[8*addr[1:0]+:8]; half mem_rdata[16*addr[1]+:16]. Zero-extend, or sign-extend if d_sign_ext. Fetch returns the raw word.
- RESP: pulse the owner's ack (d_err only for misaligned), then IDLE.
- Streak counter (sat. at MAX): +1 on data grant while if_req=1; cleared on fetch grant or when if_req=0.
- mem_ack outside *_WAIT is ignored.
- Halt asserted mid-access: in-flight access completes normally. halt blocks IDLE grants only.

## Timing
- Reset values: state IDLE, all acks/d_err/mem_req/mem_we 0, mem_addr/mem_wdata/mem_be/if_rdata/d_rdata 0, streak 0, idle 1.
- Request sampled in IDLE at cycle N: mem_req high from N+1.
- mem_ack at cycle M: ack high in M+1, idle high in M+2. Next grant is decided in M+2, so mem_req rises again at M+3.
- Minimum access: 4 cycles request-to-ack, with 1-cycle memory latency.
- Misaligned: d_ack+d_err at N+1, with no mem_req.
- Requester may change req/addr the cycle after its ack. The req value present in the ack cycle is ignored.
- Reset mid-access: mem_req low and no ack on the next cycle; a late mem_ack is ignored.

## Structure
- cpu_types package: add memory_mask_t encoding (if not present), arb_state_t enum, and byte-enable/lane helper functions.
- Natural sub-module: mem_lane_align, purely combinational. It computes be/wdata from mask+addr and extracts/extends the load lane. It is reusable by a future cache.

## Test plan
- Single load, d_addr=0x102, MEM_HALF, sign_ext=1, mem_rdata=0x8001_1234 after 2 cycles -> mem_be=0011<<2=1100, d_rdata=0xFFFF_8001, d_ack 1 cycle.
- Store byte, d_addr=0x203, wdata=0xAB -> mem_be=1000, mem_wdata=0xABAB_ABAB, mem_we=1.
- d_req and if_req held continuously, MAX_DATA_STREAK=4, 1-cycle memory -> grant order D,D,D,D,F,D,D,D,D,F.
- Misaligned MEM_WORD at 0x1001 -> no mem_req, d_ack=d_err=1 one cycle after request.
- halt=1 raised during D_WAIT with if_req pending -> data completes, no mem_req until halt=0. Then fetch is granted, if_rdata=mem_rdata.
- rst asserted during IF_WAIT, mem_ack arrives 1 cycle later -> mem_req=0, no if_ack, idle=1.
